// File: rtl/matmul_sequencer_module.sv
// Control sequencer for the matrix-multiply datapath: walks every element of C,
// steps operand line addresses through the inner dimension and strobes results out.
module matmul_sequencer_module #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int IDX_W     = (MAX_DIM > 2) ? $clog2(MAX_DIM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_bit_i,
  input  logic [1:0]            n_dim_i,
  input  logic [1:0]            k_dim_i,
  input  logic [1:0]            m_dim_i,
  output logic [ADDR_WIDTH-1:0] address_a_o,
  output logic [ADDR_WIDTH-1:0] address_b_o,
  output logic [ADDR_WIDTH-1:0] address_c_o,
  output logic [IDX_W-1:0]      col_sel_o,
  output logic                  acc_clear_o,
  output logic                  mac_en_o,
  output logic                  sp_enable_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [IDX_W-1:0] n_lat_q, n_lat_d, k_lat_q, k_lat_d, m_lat_q, m_lat_d;

  logic launch;
  logic dims_illegal;

  assign launch       = start_bit_i & ~start_q;
  assign dims_illegal = (32'(n_dim_i) >= 32'(MAX_DIM)) ||
                        (32'(k_dim_i) >= 32'(MAX_DIM)) ||
                        (32'(m_dim_i) >= 32'(MAX_DIM));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      n_lat_q <= '0;
      k_lat_q <= '0;
      m_lat_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      err_q   <= err_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      n_lat_q <= n_lat_d;
      k_lat_q <= k_lat_d;
      m_lat_q <= m_lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_bit_i;
    err_d   = 1'b0;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    n_lat_d = n_lat_q;
    k_lat_d = k_lat_q;
    m_lat_d = m_lat_q;
    unique case (state_q)
      ST_IDLE: begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
        if (launch) begin
          if (dims_illegal) err_d = 1'b1;
          else              state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        n_lat_d = IDX_W'(n_dim_i);
        k_lat_d = IDX_W'(k_dim_i);
        m_lat_d = IDX_W'(m_dim_i);
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        // k holds its last value through WRITE so the B address stays on the final row
        if (k_q == k_lat_q) state_d = ST_WRITE;
        else                k_d = k_q + 1'b1;
      end
      ST_WRITE: begin
        k_d = '0;
        if (j_q < m_lat_q) begin
          j_d     = j_q + 1'b1;
          state_d = ST_CALC;
        end else if (i_q < n_lat_q) begin
          i_d     = i_q + 1'b1;
          j_d     = '0;
          state_d = ST_CALC;
        end else begin
          i_d     = '0;
          j_d     = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    address_a_o = '0;
    address_b_o = '0;
    address_c_o = '0;
    address_a_o[5 +: IDX_W]   = i_q;
    address_b_o[5 +: IDX_W]   = k_q;
    address_c_o[5 +: 2*IDX_W] = {i_q, j_q};
    col_sel_o   = j_q;
    mac_en_o    = (state_q == ST_CALC);
    acc_clear_o = (state_q == ST_CALC) && (k_q == '0);
    sp_enable_o = (state_q == ST_WRITE);
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_DONE);
    error_o     = err_q;
  end

endmodule

// File: tb/tb_matmul_sequencer_module.sv
// Directed bench for matmul_sequencer_module: traces each run cycle by cycle
// and compares against hand-derived schedules.
module tb_matmul_sequencer_module;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_bit_i;
  logic [1:0]  n_dim_i, k_dim_i, m_dim_i;
  logic [31:0] address_a_o, address_b_o, address_c_o;
  logic [0:0]  col_sel_o;
  logic        acc_clear_o, mac_en_o, sp_enable_o, busy_o, done_o, error_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int WIN = 24;
  logic        busy_t [WIN];
  logic        sp_t   [WIN];
  logic        clr_t  [WIN];
  logic        mac_t  [WIN];
  logic        done_t [WIN];
  logic        err_t  [WIN];
  logic [31:0] adda_t [WIN];
  logic [31:0] addb_t [WIN];
  logic [31:0] addc_t [WIN];
  logic [0:0]  col_t  [WIN];
  int          chg_cyc;
  logic [1:0]  chg_n;

  matmul_sequencer_module dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_bit_i(start_bit_i),
    .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
    .address_a_o(address_a_o), .address_b_o(address_b_o), .address_c_o(address_c_o),
    .col_sel_o(col_sel_o), .acc_clear_o(acc_clear_o), .mac_en_o(mac_en_o),
    .sp_enable_o(sp_enable_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle 0 of the trace is the first negedge after the launching posedge.
  task automatic capture(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_i);
      busy_t[c] = busy_o;  sp_t[c]   = sp_enable_o; clr_t[c]  = acc_clear_o;
      mac_t[c]  = mac_en_o; done_t[c] = done_o;     err_t[c]  = error_o;
      adda_t[c] = address_a_o; addb_t[c] = address_b_o; addc_t[c] = address_c_o;
      col_t[c]  = col_sel_o;
      if (c == chg_cyc) n_dim_i = chg_n;
    end
  endtask

  task automatic launch(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m);
    start_bit_i = 1'b0;
    @(negedge clk_i);
    n_dim_i = n; k_dim_i = k; m_dim_i = m;
    start_bit_i = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] cnt;
    rst_i = 1'b1; start_bit_i = 1'b0; n_dim_i = 0; k_dim_i = 0; m_dim_i = 0;
    chg_cyc = -1; chg_n = 0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({busy_o, done_o, error_o, sp_enable_o, mac_en_o, acc_clear_o} !== 6'b0 ||
        address_a_o !== 0 || address_b_o !== 0 || address_c_o !== 0 || col_sel_o !== 0) begin
      n_fail++; $display("FAIL reset_state: outputs busy=%b done=%b err=%b sp=%b mac=%b clr=%b a=%h b=%h c=%h, required all 0",
        busy_o, done_o, error_o, sp_enable_o, mac_en_o, acc_clear_o, address_a_o, address_b_o, address_c_o);
    end
    rst_i = 1'b0;
    // abort a 2x2x2 run mid-CALC
    launch(2'd1, 2'd1, 2'd1);
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (mac_en_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_precond: mac_en=%b, required 1 in CALC", mac_en_o);
    end
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, done_o, error_o, sp_enable_o, mac_en_o, acc_clear_o} !== 6'b0 ||
        address_a_o !== 0 || address_b_o !== 0 || address_c_o !== 0) begin
      n_fail++; $display("FAIL reset_midrun: busy=%b mac=%b sp=%b a=%h c=%h, required all 0",
        busy_o, mac_en_o, sp_enable_o, address_a_o, address_c_o);
    end
    start_bit_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    capture(16);
    cnt = 0;
    for (int c = 0; c < 16; c++) cnt += {31'b0, done_t[c] | busy_t[c] | sp_t[c]};
    n_checks++;
    if (cnt !== 0) begin
      n_fail++; $display("FAIL reset_no_resume: %0d active cycles after release, required 0", cnt);
    end
  endtask

  task automatic test_2x2x2;
    int busy_n, sp_n, mac_n;
    logic [31:0] exp_c [4];
    exp_c[0] = 32'h00; exp_c[1] = 32'h20; exp_c[2] = 32'h40; exp_c[3] = 32'h60;
    launch(2'd1, 2'd1, 2'd1);
    capture(20);
    busy_n = 0; sp_n = 0; mac_n = 0;
    for (int c = 0; c < 20; c++) begin
      busy_n += int'(busy_t[c]); sp_n += int'(sp_t[c]); mac_n += int'(mac_t[c]);
    end
    n_checks++;
    if (busy_n != 14 || busy_t[0] !== 1'b1 || busy_t[14] !== 1'b0) begin
      n_fail++; $display("FAIL run222_busy: %0d busy cycles (c0=%b c14=%b), required 14 starting at c0", busy_n, busy_t[0], busy_t[14]);
    end
    n_checks++;
    if (sp_n != 4 || mac_n != 8) begin
      n_fail++; $display("FAIL run222_counts: sp=%0d mac=%0d, required sp=4 mac=8", sp_n, mac_n);
    end
    for (int e = 0; e < 4; e++) begin
      n_checks++;
      if (sp_t[3 + 3*e] !== 1'b1 || addc_t[3 + 3*e] !== exp_c[e] ||
          clr_t[1 + 3*e] !== 1'b1 || clr_t[2 + 3*e] !== 1'b0) begin
        n_fail++; $display("FAIL run222_elem%0d: sp=%b addr_c=%h clr=%b%b, required sp=1 addr_c=%h clr=10",
          e, sp_t[3 + 3*e], addc_t[3 + 3*e], clr_t[1 + 3*e], clr_t[2 + 3*e], exp_c[e]);
      end
    end
    n_checks++;
    if (adda_t[1] !== 32'h0 || adda_t[7] !== 32'h20 || addb_t[1] !== 32'h0 ||
        addb_t[2] !== 32'h20 || col_t[4] !== 1'b1 || col_t[1] !== 1'b0) begin
      n_fail++; $display("FAIL run222_addr: a1=%h a7=%h b1=%h b2=%h col4=%b col1=%b, required 0 20 0 20 1 0",
        adda_t[1], adda_t[7], addb_t[1], addb_t[2], col_t[4], col_t[1]);
    end
    n_checks++;
    if (done_t[13] !== 1'b1 || done_t[12] !== 1'b0 || done_t[14] !== 1'b0) begin
      n_fail++; $display("FAIL run222_done: done c12..14=%b%b%b, required 010", done_t[12], done_t[13], done_t[14]);
    end
  endtask

  task automatic test_held_start;
    int busy_n;
    // start_bit_i is still high from the previous run
    capture(10);
    busy_n = 0;
    for (int c = 0; c < 10; c++) busy_n += int'(busy_t[c]);
    n_checks++;
    if (busy_n != 0) begin
      n_fail++; $display("FAIL held_start: %0d busy cycles with start held, required 0", busy_n);
    end
    launch(2'd0, 2'd0, 2'd0);
    capture(6);
    n_checks++;
    if (busy_t[0] !== 1'b1 || done_t[3] !== 1'b1) begin
      n_fail++; $display("FAIL rerun: busy_c0=%b done_c3=%b, required 1 1", busy_t[0], done_t[3]);
    end
  endtask

  task automatic test_1x1x1;
    int busy_n, sp_n, nz;
    launch(2'd0, 2'd0, 2'd0);
    capture(8);
    busy_n = 0; sp_n = 0; nz = 0;
    for (int c = 0; c < 8; c++) begin
      busy_n += int'(busy_t[c]); sp_n += int'(sp_t[c]);
      if (adda_t[c] !== 0 || addb_t[c] !== 0 || addc_t[c] !== 0) nz++;
    end
    n_checks++;
    if (busy_n != 4 || sp_n != 1 || sp_t[2] !== 1'b1 || done_t[3] !== 1'b1) begin
      n_fail++; $display("FAIL run111: busy=%0d sp=%0d sp_c2=%b done_c3=%b, required 4 1 1 1",
        busy_n, sp_n, sp_t[2], done_t[3]);
    end
    n_checks++;
    if (nz != 0 || clr_t[1] !== 1'b1) begin
      n_fail++; $display("FAIL run111_addr: %0d cycles with nonzero address, clr_c1=%b, required 0 and 1", nz, clr_t[1]);
    end
  endtask

  task automatic test_dim_error;
    int busy_n, sp_n, err_n;
    launch(2'd0, 2'd2, 2'd0);
    capture(8);
    busy_n = 0; sp_n = 0; err_n = 0;
    for (int c = 0; c < 8; c++) begin
      busy_n += int'(busy_t[c]); sp_n += int'(sp_t[c]); err_n += int'(err_t[c]);
    end
    n_checks++;
    if (err_t[0] !== 1'b1 || err_n != 1 || busy_n != 0 || sp_n != 0) begin
      n_fail++; $display("FAIL dim_error: err_c0=%b errs=%0d busy=%0d sp=%0d, required 1 1 0 0",
        err_t[0], err_n, busy_n, sp_n);
    end
    launch(2'd3, 2'd0, 2'd0);
    capture(4);
    n_checks++;
    if (err_t[0] !== 1'b1 || busy_t[0] !== 1'b0) begin
      n_fail++; $display("FAIL dim_error_n3: err_c0=%b busy_c0=%b, required 1 0", err_t[0], busy_t[0]);
    end
  endtask

  task automatic test_dim_change;
    int busy_n, sp_n;
    chg_cyc = 2; chg_n = 2'd1;
    launch(2'd0, 2'd1, 2'd1);
    capture(14);
    chg_cyc = -1;
    busy_n = 0; sp_n = 0;
    for (int c = 0; c < 14; c++) begin
      busy_n += int'(busy_t[c]); sp_n += int'(sp_t[c]);
    end
    n_checks++;
    if (sp_n != 2 || busy_n != 8 || done_t[7] !== 1'b1) begin
      n_fail++; $display("FAIL dim_change: sp=%0d busy=%0d done_c7=%b, required 2 8 1", sp_n, busy_n, done_t[7]);
    end
  endtask

  initial begin
    test_reset;
    test_2x2x2;
    test_held_start;
    test_1x1x1;
    test_dim_error;
    test_dim_change;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
